imm_encoder: RTL

- Inverse of the immediate-extension stage: takes a 32-bit immediate and an immSrc format code, range-checks the immediate, and scatters its bits into the 25-bit instruction field (instruction bits [31:7]).
- Non-immediate bits (rd, funct3, rs1, rs2) come pre-placed from the requester and are merged in.
- Used by the program loader, self-test generator and verification harness to build instruction words.
- Two-stage valid/ready pipeline with error reporting and saturating statistics counters.

---
 rtl/imm_pkg.sv | 36 +++
 rtl/imm_pack.sv | 85 ++++++++
 rtl/imm_encoder.sv | 81 ++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-format encodings, error codes and payload type for the
// instruction-word immediate encoder.
package imm_pkg;

  localparam int unsigned IMM_W  = 32;
  localparam int unsigned FLD_W  = 25;
  localparam int unsigned SRC_W  = 3;
  localparam int unsigned CODE_W = 2;

  typedef enum logic [SRC_W-1:0] {
    I_T = 3'b000,
    S_T = 3'b001,
    B_T = 3'b010,
    J_T = 3'b011,
    U_T = 3'b100
  } imm_src_e;

  localparam logic [CODE_W-1:0] ERR_NONE  = 2'd0;
  localparam logic [CODE_W-1:0] ERR_RANGE = 2'd1;
  localparam logic [CODE_W-1:0] ERR_ALIGN = 2'd2;
  localparam logic [CODE_W-1:0] ERR_FMT   = 2'd3;

  typedef struct packed {
    logic [FLD_W-1:0]  data;
    logic              err;
    logic [CODE_W-1:0] code;
  } pack_res_t;

  // True when bits [31:lsb] of v are all equal (value fits a signed field).
  function automatic logic upper_same(input logic [IMM_W-1:0] v, input int unsigned lsb);
    logic [IMM_W-1:0] s;
    s = IMM_W'($signed(v) >>> lsb);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational range/alignment/format check and scatter of an immediate
// into instruction bits [31:7], merged with the caller's non-immediate fields.
module imm_pack
  import imm_pkg::*;
(
  input  logic [IMM_W-1:0]  imm,
  input  logic [SRC_W-1:0]  src,
  input  logic [FLD_W-1:0]  fields,
  output logic [FLD_W-1:0]  data,
  output logic              err,
  output logic [CODE_W-1:0] code
);

  logic [FLD_W-1:0] put;
  logic [FLD_W-1:0] msk;
  logic             fmt_ok;
  logic             align_ok;
  logic             in_range;

  always_comb begin
    put      = '0;
    msk      = '0;
    fmt_ok   = 1'b1;
    align_ok = 1'b1;
    in_range = 1'b0;
    case (src)
      I_T: begin
        msk         = 25'h1FFE000;
        put[24:13]  = imm[11:0];
        in_range    = upper_same(imm, 11);
      end
      S_T: begin
        msk         = 25'h1FC001F;
        put[24:18]  = imm[11:5];
        put[4:0]    = imm[4:0];
        in_range    = upper_same(imm, 11);
      end
      B_T: begin
        msk         = 25'h1FC001F;
        put[24]     = imm[12];
        put[23:18]  = imm[10:5];
        put[4:1]    = imm[4:1];
        put[0]      = imm[11];
        align_ok    = ~imm[0];
        in_range    = upper_same(imm, 12);
      end
      J_T: begin
        msk         = 25'h1FFFFE0;
        put[24]     = imm[20];
        put[23:14]  = imm[10:1];
        put[13]     = imm[11];
        put[12:5]   = imm[19:12];
        align_ok    = ~imm[0];
        in_range    = upper_same(imm, 20);
      end
      U_T: begin
        msk         = 25'h1FFFFE0;
        put[24:5]   = imm[31:12];
        in_range    = (imm[11:0] == 12'd0);
      end
      default: fmt_ok = 1'b0;
    endcase
  end

  // Priority: bad format > misaligned > range; rejected requests keep fields only.
  always_comb begin
    data = (fields & ~msk) | put;
    err  = 1'b0;
    code = ERR_NONE;
    if (!fmt_ok) begin
      data = fields;
      err  = 1'b1;
      code = ERR_FMT;
    end else if (!align_ok) begin
      data = fields & ~msk;
      err  = 1'b1;
      code = ERR_ALIGN;
    end else if (!in_range) begin
      data = fields & ~msk;
      err  = 1'b1;
      code = ERR_RANGE;
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder with error reporting and
// saturating encode/error statistics.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SRC_W-1:0]  in_imm_src,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [FLD_W-1:0]  in_fields,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLD_W-1:0]  out_data,
  output logic              out_err,
  output logic [CODE_W-1:0] out_err_code,
  output logic [CNT_W-1:0]  enc_count,
  output logic [CNT_W-1:0]  err_count
);

  pack_res_t pk;
  pack_res_t s1_q;
  logic      s1_valid;
  logic      s2_load;
  logic      out_hs;

  imm_pack u_pack (
    .imm    (in_imm),
    .src    (in_imm_src),
    .fields (in_fields),
    .data   (pk.data),
    .err    (pk.err),
    .code   (pk.code)
  );

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign out_hs   = out_valid && out_ready;

  // Stage 1: request check result; emptied when it advances with no new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= pk;
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_err      <= 1'b0;
      out_err_code <= ERR_NONE;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= s1_q.data;
        out_err      <= s1_q.err;
        out_err_code <= s1_q.code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_hs) begin
      if (!out_err && (enc_count != '1)) enc_count <= enc_count + CNT_W'(1);
      if (out_err && (err_count != '1))  err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
